// File: rtl/vga_user_capture_if.sv
// vga_user_capture_if: VGA timing, user button and PIO status word that pass
// between the timing/button source (master) and the capture block (slave).
interface vga_user_capture_if;
    logic        vga_hs_n;
    logic        vga_vs_n;
    logic        vga_de;
    logic        btn_n;
    logic [21:0] pio_data;

    modport master (
        output vga_hs_n,
        output vga_vs_n,
        output vga_de,
        output btn_n,
        input  pio_data
    );

    modport slave (
        input  vga_hs_n,
        input  vga_vs_n,
        input  vga_de,
        input  btn_n,
        output pio_data
    );
endinterface

// File: rtl/vga_user_capture.sv
// vga_user_capture: follows the VGA timing stream, debounces the user button
// and, on each press, latches the screen coordinate of the next active pixel
// into the 22-bit PIO status word polled by the HPS.
//   pio_data[9:0]   captured x
//   pio_data[19:10] captured y
//   pio_data[20]    capture toggle (flips on every new sample)
//   pio_data[21]    timing locked (last frame had exactly V_ACTIVE lines)
// Build option: define VGA_CAPTURE_DEBOUNCE_EN to enable the debounce counter;
// without it the synchronised button is used directly.
// vga_hs_n is carried in the interface for completeness; line tracking is
// derived from data-enable edges, so the capture logic does not need it.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a debounced button press
// ST_ARMED | press seen, capture the coordinate of the next de=1 pixel
// ST_HOLD  | sample taken, waiting for the button to be released
module vga_user_capture #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int DEB_CYCLES = 250000
) (
    input  logic               clk,
    input  logic               reset_n,
    vga_user_capture_if.slave  vga
);

    localparam logic [9:0]  X_MAX   = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_MAX   = 10'(V_ACTIVE - 1);
    localparam logic [10:0] V_LINES = 11'(V_ACTIVE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // button synchroniser (released = 1 out of reset)
    logic btn_s1_q, btn_s1_d;
    logic btn_s2_q, btn_s2_d;

    // debounced button, current value and value it takes at the next edge
    logic btn_db;
    logic btn_db_nxt;
    logic btn_fall;

    // timing edge detection
    logic de_prev_q, de_prev_d;
    logic vs_prev_q, vs_prev_d;
    logic de_fall;
    logic vs_fall;

    // coordinate and lock tracking
    logic [9:0]  x_cnt_q, x_cnt_d;
    logic [9:0]  y_cnt_q, y_cnt_d;
    logic [10:0] line_cnt_q, line_cnt_d;
    logic        locked_q, locked_d;

    // capture FSM and captured sample
    state_t      state_q, state_d;
    logic [20:0] cap_q, cap_d;

    // two-stage synchroniser for the asynchronous button
    always_comb begin
        btn_s1_d = vga.btn_n;
        btn_s2_d = btn_s1_q;
    end

    // synchroniser flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_s1_q <= 1'b1;
            btn_s2_q <= 1'b1;
        end else begin
            btn_s1_q <= btn_s1_d;
            btn_s2_q <= btn_s2_d;
        end
    end

`ifdef VGA_CAPTURE_DEBOUNCE_EN
    localparam int             DEB_W    = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LOAD = DEB_W'((DEB_CYCLES < 1) ? 0 : DEB_CYCLES - 1);

    logic             btn_db_q, btn_db_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

    // down-counter reloads whenever the input agrees with the accepted level;
    // the new level is accepted when it has differed for DEB_CYCLES clocks
    always_comb begin
        btn_db_d  = btn_db_q;
        deb_cnt_d = deb_cnt_q;
        if (btn_s2_q == btn_db_q) begin
            deb_cnt_d = DEB_LOAD;
        end else if (deb_cnt_q == '0) begin
            btn_db_d  = btn_s2_q;
            deb_cnt_d = DEB_LOAD;
        end else begin
            deb_cnt_d = deb_cnt_q - 1'b1;
        end
    end

    // debounce flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_db_q  <= 1'b1;
            deb_cnt_q <= DEB_LOAD;
        end else begin
            btn_db_q  <= btn_db_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign btn_db     = btn_db_q;
    assign btn_db_nxt = btn_db_d;
`else
    assign btn_db     = btn_s2_q;
    assign btn_db_nxt = btn_s2_d;
`endif

    // press is taken on the edge where the debounced level goes low, so the
    // FSM is armed on the same edge the press becomes visible
    assign btn_fall = btn_db & ~btn_db_nxt;

    assign de_fall  = de_prev_q & ~vga.vga_de;
    assign vs_fall  = vs_prev_q & ~vga.vga_vs_n;

    // pixel/line counters and frame lock check
    always_comb begin
        de_prev_d  = vga.vga_de;
        vs_prev_d  = vga.vga_vs_n;
        locked_d   = locked_q;
        line_cnt_d = line_cnt_q;
        y_cnt_d    = y_cnt_q;

        if (vga.vga_de) begin
            x_cnt_d = (x_cnt_q == X_MAX) ? x_cnt_q : x_cnt_q + 10'd1;
        end else begin
            x_cnt_d = '0;
        end

        if (vs_fall) begin
            // line count of the frame just finished, before it is cleared
            locked_d   = (line_cnt_q == V_LINES);
            line_cnt_d = '0;
            y_cnt_d    = '0;
        end else if (de_fall) begin
            line_cnt_d = line_cnt_q + 11'd1;
            if (y_cnt_q != Y_MAX) begin
                y_cnt_d = y_cnt_q + 10'd1;
            end
        end
    end

    // capture FSM: one sample per press, coordinate taken before the counters
    // advance so the sample matches the pixel presented this cycle
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        case (state_q)
            ST_IDLE: begin
                if (btn_fall) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (vga.vga_de) begin
                    cap_d   = {~cap_q[20], y_cnt_q, x_cnt_q};
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (btn_db) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // timing, lock and FSM state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            de_prev_q  <= 1'b0;
            vs_prev_q  <= 1'b1;
            x_cnt_q    <= '0;
            y_cnt_q    <= '0;
            line_cnt_q <= '0;
            locked_q   <= 1'b0;
            state_q    <= ST_IDLE;
            cap_q      <= '0;
        end else begin
            de_prev_q  <= de_prev_d;
            vs_prev_q  <= vs_prev_d;
            x_cnt_q    <= x_cnt_d;
            y_cnt_q    <= y_cnt_d;
            line_cnt_q <= line_cnt_d;
            locked_q   <= locked_d;
            state_q    <= state_d;
            cap_q      <= cap_d;
        end
    end

    assign vga.pio_data = {locked_q, cap_q};

endmodule

// File: tb/tb_vga_user_capture.sv
// tb_vga_user_capture: directed checks of reset, frame lock, capture
// coordinates, press latency and the optional debounce build.
// Frames are shortened (few pixels per line) except for the one long line
// that carries the x=301 capture; lock depends only on the line count.
`timescale 1ns/1ps
module tb_vga_user_capture;

    localparam int H_ACTIVE   = 320;
    localparam int V_ACTIVE   = 120;
    localparam int DEB_CYCLES = 16;
`ifdef VGA_CAPTURE_DEBOUNCE_EN
    // 2 sync edges + DEB_CYCLES stable edges until the FSM is armed
    localparam int PRESS_LAT  = DEB_CYCLES + 2;
`else
    localparam int PRESS_LAT  = 2;
`endif
    localparam int RELEASE_TICKS = PRESS_LAT + 6;
    localparam int LINE_PIX      = 8;
    localparam int H_BLANK       = 4;
    localparam int V_BP          = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    vga_user_capture_if vif ();

    vga_user_capture #(
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .vga     (vif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic hblank();
        vif.vga_de   = 1'b0;
        vif.vga_hs_n = 1'b0;
        tick();
        vif.vga_hs_n = 1'b1;
        idle(H_BLANK - 1);
    endtask

    task automatic lines(input int n, input int npix);
        for (int l = 0; l < n; l++) begin
            for (int p = 0; p < npix; p++) begin
                vif.vga_de = 1'b1;
                tick();
            end
            hblank();
        end
    endtask

    // one active line; the button goes low in the cycle presenting press_at
    task automatic line_press(input int npix, input int press_at);
        for (int p = 0; p < npix; p++) begin
            if (p == press_at) vif.btn_n = 1'b0;
            vif.vga_de = 1'b1;
            tick();
        end
        hblank();
    endtask

    task automatic vsync();
        vif.vga_vs_n = 1'b0;
        idle(2);
        vif.vga_vs_n = 1'b1;
        idle(V_BP);
    endtask

    function automatic logic [31:0] px();
        return 32'(vif.pio_data[9:0]);
    endfunction
    function automatic logic [31:0] py();
        return 32'(vif.pio_data[19:10]);
    endfunction
    function automatic logic [31:0] ptog();
        return 32'(vif.pio_data[20]);
    endfunction
    function automatic logic [31:0] plock();
        return 32'(vif.pio_data[21]);
    endfunction

    initial begin
        reset_n      = 1'b0;
        vif.vga_hs_n = 1'b1;
        vif.vga_vs_n = 1'b1;
        vif.vga_de   = 1'b0;
        vif.btn_n    = 1'b1;
        idle(3);
        chk("reset_pio", 32'(vif.pio_data), 32'd0);
        reset_n = 1'b1;
        idle(2);

        // frame lock: first vs fall sees no lines, then 120/119/120/121/120
        vsync();
        chk("lock_first", plock(), 32'd0);
        lines(V_ACTIVE, LINE_PIX);
        vsync();
        chk("lock_120", plock(), 32'd1);
        chk("no_capture", 32'(vif.pio_data[20:0]), 32'd0);
        lines(V_ACTIVE - 1, LINE_PIX);
        vsync();
        chk("lock_119", plock(), 32'd0);
        lines(V_ACTIVE, LINE_PIX);
        vsync();
        chk("relock_120", plock(), 32'd1);
        lines(V_ACTIVE + 1, LINE_PIX);
        vsync();
        chk("lock_121", plock(), 32'd0);
        lines(V_ACTIVE, LINE_PIX);
        vsync();
        chk("lock_again", plock(), 32'd1);

        // press timed so the FSM arms at the end of pixel 300 on line 100
        lines(100, LINE_PIX);
        line_press(H_ACTIVE, 301 - PRESS_LAT);
        chk("mid_x", px(), 32'd301);
        chk("mid_y", py(), 32'd100);
        chk("mid_tog", ptog(), 32'd1);
        vif.btn_n = 1'b1;
        lines(V_ACTIVE - 101, LINE_PIX);

        // press in vertical blank, armed across the vs fall, held for 3 lines
        vif.btn_n = 1'b0;
        idle(PRESS_LAT);
        vsync();
        chk("vb_lock", plock(), 32'd1);
        lines(3, LINE_PIX);
        chk("vb_x", px(), 32'd0);
        chk("vb_y", py(), 32'd0);
        chk("vb_tog", ptog(), 32'd0);
        vif.btn_n = 1'b1;
        idle(RELEASE_TICKS);

`ifdef VGA_CAPTURE_DEBOUNCE_EN
        // bouncy press never stable for DEB_CYCLES: no capture
        vif.btn_n = 1'b0; idle(3);
        vif.btn_n = 1'b1; idle(2);
        vif.btn_n = 1'b0; idle(10);
        vif.btn_n = 1'b1; idle(RELEASE_TICKS);
        lines(1, 40);
        chk("deb_bounce_tog", ptog(), 32'd0);
        // 20-clock stable press: one capture at the next de pixel
        vif.btn_n = 1'b0;
        idle(20);
        lines(1, LINE_PIX);
        chk("deb_press_tog", ptog(), 32'd1);
        chk("deb_press_x", px(), 32'd0);
        vif.btn_n = 1'b1;
        idle(RELEASE_TICKS);
        lines(1, LINE_PIX);
        chk("deb_release_tog", ptog(), 32'd1);
`else
        // armed exactly two edges after btn_n falls: de on edge 2 is missed,
        // de on edge 3 captures x=1
        vif.btn_n = 1'b0;
        tick();
        vif.vga_de = 1'b1;
        tick();
        chk("lat_early_tog", ptog(), 32'd0);
        tick();
        chk("lat_x", px(), 32'd1);
        chk("lat_tog", ptog(), 32'd1);
        vif.vga_de = 1'b0;
        vif.btn_n  = 1'b1;
        idle(RELEASE_TICKS);
`endif

        // reset mid-frame while ARMED
        chk("pre_reset_lock", plock(), 32'd1);
        vif.btn_n = 1'b0;
        idle(PRESS_LAT + 2);
        reset_n = 1'b0;
        #1;
        chk("reset_async_pio", 32'(vif.pio_data), 32'd0);
        vif.btn_n = 1'b1;
        idle(3);
        reset_n = 1'b1;
        lines(2, LINE_PIX);
        chk("reset_no_capture", 32'(vif.pio_data), 32'd0);
        vsync();
        chk("reset_lock", plock(), 32'd0);
        lines(V_ACTIVE, LINE_PIX);
        vsync();
        chk("reset_relock", plock(), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
